axi4_lite_ctrl_arbiter: RTL and testbench
=========================================

Name: axi4_lite_ctrl_arbiter

Overview:
- Shares one axi4_lite_master control port between NUM_REQ independent requesters, such as a CPU-side bridge, a DMA descriptor fetcher and a debug port.
- Grants requesters round-robin and sequences one transaction at a time: issue, wait for done, return response.
- Sits between the requesters and the ctrl_* port of the AXI4-lite master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 256, WAIT-state cycle limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  [NUM_REQ-1:0]  per-requester request, held until that requester's req_done.
- req_write  in  [NUM_REQ-1:0]  1 = write, 0 = read.
- req_addr  in  [NUM_REQ-1:0][31:0]  byte address.
- req_wdata  in  [NUM_REQ-1:0][31:0]  write data.
- req_wstrb  in  [NUM_REQ-1:0][3:0]  write strobes.
- req_done  out  [NUM_REQ-1:0]  one-hot, one-cycle completion pulse.
- rsp_rdata  out  32  read data; valid while any req_done bit is high.
- rsp_resp  out  2  BRESP or RRESP; valid while any req_done bit is high.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- ctrl_write_req, ctrl_read_req  out  1  one-cycle issue pulses to the master.
- ctrl_waddr, ctrl_raddr, ctrl_wdata  out  32  registered copies of the granted request.
- ctrl_wstrb  out  4  registered strobes.
- ctrl_write_done, ctrl_read_done  in  1  completion pulses from the master.
- ctrl_rdata  in  32  read data from the master.
- ctrl_bresp, ctrl_rresp  in  2  write and read responses from the master.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer 0.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after the pointer, scanning upward with wrap.
  - Register addr, data, strobes and direction of the winner into the ctrl_* registers; set grant_id; go to ISSUE.
  - Pointer becomes grant+1 mod NUM_REQ.
- ISSUE, exactly 1 cycle:
  - Assert ctrl_write_req or ctrl_read_req according to the latched direction, never both.
  - Both ctrl_waddr and ctrl_raddr carry the latched address.
  - Go to WAIT.
- WAIT:
  - Hold all ctrl_* registers stable.
  - On the done pulse matching the latched direction, capture rdata (reads only; writes capture 0) and the matching resp, then go to RESP.
  - A done pulse for the opposite direction is ignored.
- RESP, 1 cycle: req_done[grant_id]=1 with rsp_rdata and rsp_resp valid; go to IDLE.
- Latency: req_valid sampled in IDLE at cycle N gives a ctrl_*_req pulse at N+1. Master done at cycle M gives req_done at M+1. Minimum gap between back-to-back grants is 1 IDLE cycle.
- Requester rules:
  - Drop req_valid on the edge that ends its req_done cycle, unless it is immediately issuing a new request.
  - Fields must stay stable while req_valid is high.
  - A req_valid withdrawn before grant is simply not granted. Withdrawal after grant does not abort the in-flight transaction.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- Done pulses arriving in IDLE, ISSUE or RESP are dropped. A done arriving in the ISSUE cycle itself is a master protocol violation and is not handled.
- Reset asserted mid-transaction returns everything to reset values immediately; the in-flight transaction is abandoned with no req_done.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A WAIT counter starts at 0 on WAIT entry.
  - If it reaches TIMEOUT_CYCLES without a matching done, go to RESP with rsp_resp=2'b10 (SLVERR) and rsp_rdata=0.
  - A late done arriving afterwards is dropped.
- Undefined: no counter; WAIT waits indefinitely.

Decomposition:
- Package axi4_lite_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- Sub-module rr_arbiter (parameter N): combinational mask-and-priority grant from a request vector and pointer, producing a one-hot grant and an index.

Test Plan:
- Single write: req 0 writes addr 0x10, data 0xDEADBEEF, wstrb 0xF; master done after 5 cycles with bresp 0 -> one ctrl_write_req pulse carrying those values; req_done=4'b0001 one cycle after done with rsp_resp=0.
- Single read: req 2 reads 0x20; master returns rdata 0x12345678, rresp 0 -> req_done=4'b0100 with rsp_rdata=0x12345678.
- All four requesters held valid for 8 transactions -> grant_id sequence 0,1,2,3,0,1,2,3 with no ctrl_req overlap.
- Stray ctrl_read_done during a write's WAIT -> ignored; completion occurs only on ctrl_write_done.
- rst_n pulsed low while in WAIT -> outputs 0 and busy=0 asynchronously; no req_done; next request is granted from pointer 0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, master never responds -> req_done after 16 WAIT cycles with rsp_resp=2'b10 and rsp_rdata=0.

Source files
------------

// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and response codes for the AXI4-lite control-port arbiter.
package axi4_lite_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr, else
// the lowest request overall.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [N-1:0] upper;
   logic         hit;

   always_comb begin
      upper = '0;
      for (int i = 0; i < N; i++) begin
         if (i >= int'(ptr)) upper[i] = req[i];
      end
   end

   always_comb begin
      idx = '0;
      hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!hit && upper[i]) begin
            hit = 1'b1;
            idx = IW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!hit && req[i]) begin
            hit = 1'b1;
            idx = IW'(i);
         end
      end
   end

   assign any   = |req;
   assign grant = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/axi4_lite_ctrl_arbiter.sv
// Round-robin sharing of one AXI4-lite master control port.
// Optional WAIT timeout enabled by defining ARB_TIMEOUT_EN.
module axi4_lite_ctrl_arbiter
   import axi4_lite_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_write,
   input  logic [NUM_REQ-1:0][31:0] req_addr,
   input  logic [NUM_REQ-1:0][31:0] req_wdata,
   input  logic [NUM_REQ-1:0][3:0]  req_wstrb,
   output logic [NUM_REQ-1:0]       req_done,
   output logic [31:0]              rsp_rdata,
   output logic [1:0]               rsp_resp,
   output logic [IW-1:0]            grant_id,
   output logic                     busy,
   output logic                     ctrl_write_req,
   output logic                     ctrl_read_req,
   output logic [31:0]              ctrl_waddr,
   output logic [31:0]              ctrl_raddr,
   output logic [31:0]              ctrl_wdata,
   output logic [3:0]               ctrl_wstrb,
   input  logic                     ctrl_write_done,
   input  logic                     ctrl_read_done,
   input  logic [31:0]              ctrl_rdata,
   input  logic [1:0]               ctrl_bresp,
   input  logic [1:0]               ctrl_rresp
);

   arb_state_t state, state_nx;

   logic [NUM_REQ-1:0] gnt_oh;
   logic [IW-1:0]      gnt_idx;
   logic               gnt_any;
   logic [IW-1:0]      ptr;
   logic               dir_wr;
   logic [31:0]        addr_q;
   logic               done_hit;
   logic               to_hit;

   logic               sel_wr;
   logic [31:0]        sel_addr;
   logic [31:0]        sel_wdata;
   logic [3:0]         sel_wstrb;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (gnt_oh),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

   // One-hot AND-OR select of the winner's fields
   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wstrb = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_wr    |= gnt_oh[i] & req_write[i];
         sel_addr  |= {32{gnt_oh[i]}} & req_addr[i];
         sel_wdata |= {32{gnt_oh[i]}} & req_wdata[i];
         sel_wstrb |= {4{gnt_oh[i]}} & req_wstrb[i];
      end
   end

   assign done_hit = (state == WAIT) &&
                     (dir_wr ? ctrl_write_done : ctrl_read_done);

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state != WAIT) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end

   assign to_hit = (state == WAIT) &&
                   (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (gnt_any) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (done_hit || to_hit) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= '0;
         grant_id   <= '0;
         dir_wr     <= 1'b0;
         addr_q     <= '0;
         ctrl_wdata <= '0;
         ctrl_wstrb <= '0;
         rsp_rdata  <= '0;
         rsp_resp   <= RESP_OKAY;
      end else begin
         if (state == IDLE && gnt_any) begin
            grant_id   <= gnt_idx;
            ptr        <= (gnt_idx == IW'(NUM_REQ - 1)) ?
                          '0 : gnt_idx + IW'(1);
            dir_wr     <= sel_wr;
            addr_q     <= sel_addr;
            ctrl_wdata <= sel_wdata;
            ctrl_wstrb <= sel_wstrb;
         end
         // A real completion wins over a same-cycle timeout
         if (done_hit) begin
            rsp_rdata <= dir_wr ? 32'h0 : ctrl_rdata;
            rsp_resp  <= dir_wr ? ctrl_bresp : ctrl_rresp;
         end else if (to_hit) begin
            rsp_rdata <= 32'h0;
            rsp_resp  <= RESP_SLVERR;
         end
      end
   end

   assign busy           = (state != IDLE);
   assign ctrl_write_req = (state == ISSUE) && dir_wr;
   assign ctrl_read_req  = (state == ISSUE) && !dir_wr;
   assign ctrl_waddr     = addr_q;
   assign ctrl_raddr     = addr_q;
   assign req_done       = (state == RESP) ?
                           (NUM_REQ'(1) << grant_id) : '0;

endmodule

// File: tb/tb_axi4_lite_ctrl_arbiter.sv
// Scoreboard bench for axi4_lite_ctrl_arbiter with a simple master model.
module tb_axi4_lite_ctrl_arbiter;

   localparam int NR = 4;
   localparam int TO = 16;
   localparam logic [31:0] RD_KEY = 32'h1234_5658;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NR-1:0]       req_valid;
   logic [NR-1:0]       req_write;
   logic [NR-1:0][31:0] req_addr;
   logic [NR-1:0][31:0] req_wdata;
   logic [NR-1:0][3:0]  req_wstrb;
   logic [NR-1:0]       req_done;
   logic [31:0]         rsp_rdata;
   logic [1:0]          rsp_resp;
   logic [1:0]          grant_id;
   logic                busy;
   logic                ctrl_write_req, ctrl_read_req;
   logic [31:0]         ctrl_waddr, ctrl_raddr, ctrl_wdata;
   logic [3:0]          ctrl_wstrb;
   logic                ctrl_write_done, ctrl_read_done;
   logic [31:0]         ctrl_rdata;
   logic [1:0]          ctrl_bresp, ctrl_rresp;

   axi4_lite_ctrl_arbiter #(
      .NUM_REQ(NR),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_wstrb(req_wstrb), .req_done(req_done),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .grant_id(grant_id), .busy(busy),
      .ctrl_write_req(ctrl_write_req), .ctrl_read_req(ctrl_read_req),
      .ctrl_waddr(ctrl_waddr), .ctrl_raddr(ctrl_raddr),
      .ctrl_wdata(ctrl_wdata), .ctrl_wstrb(ctrl_wstrb),
      .ctrl_write_done(ctrl_write_done), .ctrl_read_done(ctrl_read_done),
      .ctrl_rdata(ctrl_rdata), .ctrl_bresp(ctrl_bresp),
      .ctrl_rresp(ctrl_rresp)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [1:0]  id;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } iss_t;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] rdata;
      logic [1:0]  resp;
   } cpl_t;

   iss_t iq[$];
   cpl_t cq[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cyc = 0;
   bit mst_en = 1'b0;
   bit stray_en = 1'b0;
   bit to_mode = 1'b0;
   int mst_lat = 5;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic post(input int id, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input bit exp_cpl);
      iss_t e;
      cpl_t c;
      req_write[id] = wr;
      req_addr[id]  = a;
      req_wdata[id] = d;
      req_wstrb[id] = s;
      req_valid[id] = 1'b1;
      e = '{2'(id), wr, a, d, s};
      iq.push_back(e);
      if (exp_cpl) begin
         c = '{2'(id), wr ? 32'h0 : (a ^ RD_KEY), a[3:2]};
         cq.push_back(c);
      end
   endtask

   task automatic wait_issue(output int at);
      bit got = 1'b0;
      at = 0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (ctrl_write_req || ctrl_read_req) begin
            got = 1'b1;
            at = cyc;
         end
      end
      chk("wait_issue", got, 1);
   endtask

   task automatic wait_done(input int id, output int at);
      bit got = 1'b0;
      at = 0;
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         if (req_done[id]) begin
            got = 1'b1;
            at = cyc;
            req_valid[id] = 1'b0;
         end
      end
      chk("wait_done", got, 1);
   endtask

   initial forever begin
      @(posedge clk);
      if (ctrl_write_done || ctrl_read_done) done_cyc = cyc;
      cyc++;
   end

   // Output monitor: pops issue and completion expectations
   initial begin
      iss_t e;
      cpl_t c;
      logic [3:0] oh;
      forever begin
         @(negedge clk);
         if (rst_n && (ctrl_write_req || ctrl_read_req)) begin
            chk("req_excl", ctrl_write_req && ctrl_read_req, 0);
            chk("iss_q", iq.size() > 0, 1);
            if (iq.size() > 0) begin
               e = iq.pop_front();
               chk("iss_dir", ctrl_write_req, e.wr);
               chk("iss_gid", grant_id, e.id);
               chk("iss_waddr", ctrl_waddr, e.addr);
               chk("iss_raddr", ctrl_raddr, e.addr);
               if (e.wr) begin
                  chk("iss_wdata", ctrl_wdata, e.wdata);
                  chk("iss_wstrb", ctrl_wstrb, e.wstrb);
               end
            end
         end
         if (rst_n && |req_done) begin
            chk("cpl_q", cq.size() > 0, 1);
            if (cq.size() > 0) begin
               c = cq.pop_front();
               oh = 4'b0001 << c.id;
               chk("cpl_done", req_done, oh);
               chk("cpl_rdata", rsp_rdata, c.rdata);
               chk("cpl_resp", rsp_resp, c.resp);
               chk("cpl_busy", busy, 1);
               if (!to_mode) chk("cpl_lat", cyc - done_cyc, 1);
            end
         end
      end
   end

   // Master model, optionally with a stray opposite-direction done
   initial begin
      logic [31:0] a;
      bit wr;
      ctrl_write_done = 1'b0;
      ctrl_read_done  = 1'b0;
      ctrl_rdata      = '0;
      ctrl_bresp      = '0;
      ctrl_rresp      = '0;
      forever begin
         @(negedge clk);
         if (mst_en && rst_n && (ctrl_write_req || ctrl_read_req)) begin
            a  = ctrl_waddr;
            wr = ctrl_write_req;
            for (int k = 1; k <= mst_lat; k++) begin
               @(negedge clk);
               ctrl_write_done = 1'b0;
               ctrl_read_done  = 1'b0;
               if (stray_en && k == 2) begin
                  ctrl_rdata = '1;
                  ctrl_bresp = 2'b11;
                  ctrl_rresp = 2'b11;
                  if (wr) ctrl_read_done = 1'b1;
                  else    ctrl_write_done = 1'b1;
               end
            end
            ctrl_rdata = a ^ RD_KEY;
            ctrl_bresp = a[3:2];
            ctrl_rresp = a[3:2];
            ctrl_write_done = wr;
            ctrl_read_done  = !wr;
            @(negedge clk);
            ctrl_write_done = 1'b0;
            ctrl_read_done  = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int s, at, t_iss, total;
      int cnt[NR];
      cpl_t c;
      rst_n     = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", req_done, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_waddr", ctrl_waddr, 0);
      chk("rst_reqs", {ctrl_write_req, ctrl_read_req}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_resp", rsp_resp, 0);
      rst_n = 1'b1;
      @(negedge clk);

      mst_en  = 1'b1;
      mst_lat = 5;
      s = cyc;
      post(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
      wait_issue(at);
      chk("iss_lat", at - s, 1);
      wait_done(0, at);
      @(negedge clk);

      post(2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
      wait_done(2, at);
      @(negedge clk);

      stray_en = 1'b1;
      mst_lat  = 8;
      post(1, 1'b1, 32'h44, 32'hCAFE_F00D, 4'h3, 1'b1);
      wait_done(1, at);
      stray_en = 1'b0;
      mst_lat  = 3;
      @(negedge clk);

      mst_en = 1'b0;
      post(2, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
      wait_issue(at);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", req_done, 0);
      chk("arst_reqs", {ctrl_write_req, ctrl_read_req}, 0);
      chk("arst_waddr", ctrl_waddr, 0);
      chk("arst_gid", grant_id, 0);
      req_valid = '0;
      @(negedge clk);
      rst_n  = 1'b1;
      mst_en = 1'b1;
      @(negedge clk);
      post(1, 1'b1, 32'h104, 32'h1111_0001, 4'h1, 1'b1);
      post(3, 1'b0, 32'h10C, 32'h0, 4'h0, 1'b1);
      wait_done(1, at);
      wait_done(3, at);
      @(negedge clk);

      mst_lat = 2;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NR; i++) begin
            post(i, i[0], 32'h200 + 32'(4 * i), 32'hA000 + 32'(i),
                 4'(1 << i), 1'b1);
         end
      end
      total = 0;
      for (int i = 0; i < NR; i++) cnt[i] = 0;
      for (int k = 0; k < 400 && total < 8; k++) begin
         @(negedge clk);
         for (int i = 0; i < NR; i++) begin
            if (req_done[i]) begin
               cnt[i]++;
               total++;
               if (cnt[i] == 2) req_valid[i] = 1'b0;
            end
         end
      end
      chk("fair_total", total, 8);
      @(negedge clk);

`ifdef ARB_TIMEOUT_EN
      to_mode = 1'b1;
      mst_lat = 20;
      post(3, 1'b0, 32'h54, 32'h0, 4'h0, 1'b0);
      c = '{2'd3, 32'h0, 2'b10};
      cq.push_back(c);
      wait_issue(t_iss);
      wait_done(3, at);
      chk("to_lat", at - t_iss, TO + 1);
      repeat (10) @(negedge clk);
      to_mode = 1'b0;
`else
      t_iss = 0;
`endif

      repeat (5) @(negedge clk);
      chk("iq_empty", iq.size(), 0);
      chk("cq_empty", cq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
